// File: rtl/branch_predictor_pkg.sv
// Shared encodings for the fetch-side branch predictor and the execute-side
// branch resolver: PC-select codes, opcode classes, branch funct3 values,
// 2-bit saturating counter states and ALU flag bit positions.
package pc_pkg;

  // Next-PC source selected by the execute stage.
  typedef enum logic [1:0] {
    PC_PLUS4 = 2'b00,
    PC_IMM   = 2'b01,
    PC_JALR  = 2'b10
  } pcsrc_e;

  // OP[6] marks a control-transfer instruction; OP[3:2] splits the class.
  localparam int unsigned OP_CTRL_BIT = 6;
  localparam logic [1:0]  OPC_JALR    = 2'b01;
  localparam logic [1:0]  OPC_JAL     = 2'b11;

  // Conditional-branch funct3 values (010/011 are never taken).
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // 2-bit saturating direction counter; MSB set means predict taken.
  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  // ONZC flag bit positions.
  localparam int unsigned ONZC_LTU = 3;
  localparam int unsigned ONZC_LT  = 2;
  localparam int unsigned ONZC_Z   = 1;
  localparam int unsigned ONZC_C   = 0;

  function automatic ctr_e ctr_next(input ctr_e c, input logic taken);
    ctr_e n;
    n = c;
    unique case (c)
      SNT: n = taken ? WNT : SNT;
      WNT: n = taken ? WT  : SNT;
      WT:  n = taken ? ST  : WNT;
      ST:  n = taken ? ST  : WT;
      default: n = WNT;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/branch_predictor_resolve.sv
// Combinational branch resolver: decodes OP/Funct3/ONZC of the instruction in
// execute into the actual taken outcome and the PC-select code.
//   OP     in  7  opcode of resolving instruction
//   Funct3 in  3  branch condition
//   ONZC   in  4  ALU flags {ltu, lt, zero, carry}
//   Taken  out 1  control transfer actually taken
//   PCSrc  out 2  00 PC+4, 01 PC+imm, 10 jalr
module branch_resolve
  import pc_pkg::*;
(
  input  logic [6:0] OP,
  input  logic [2:0] Funct3,
  input  logic [3:0] ONZC,
  output logic       Taken,
  output logic [1:0] PCSrc
);

  logic w_unused;
  assign w_unused = ^{OP[5:4], OP[1:0], ONZC[ONZC_C]};

  always_comb begin
    Taken = 1'b0;
    PCSrc = PC_PLUS4;
    if (OP[OP_CTRL_BIT]) begin
      case (OP[3:2])
        OPC_JALR: begin
          Taken = 1'b1;
          PCSrc = PC_JALR;
        end
        OPC_JAL: begin
          Taken = 1'b1;
          PCSrc = PC_IMM;
        end
        default: begin
          case (Funct3)
            F3_BEQ:  Taken =  ONZC[ONZC_Z];
            F3_BNE:  Taken = ~ONZC[ONZC_Z];
            F3_BLT:  Taken =  ONZC[ONZC_LT];
            F3_BGE:  Taken = ~ONZC[ONZC_LT];
            F3_BLTU: Taken =  ONZC[ONZC_LTU];
            F3_BGEU: Taken = ~ONZC[ONZC_LTU];
            default: Taken = 1'b0;
          endcase
          PCSrc = Taken ? PC_IMM : PC_PLUS4;
        end
      endcase
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating direction counters. Fetch-side
// lookup is combinational; execute-side resolution flags mispredicts, supplies
// the redirect PC and updates the tables on the clock edge. Also keeps
// saturating counts of resolved control instructions and mispredicts.
//   clk, reset            clock, synchronous active-high reset
//   FetchPC               PC being fetched
//   PredTaken/PredTarget  fetch prediction
//   ResValid, ResPC, OP, Funct3, ONZC, ResTarget,
//   ResPredTaken, ResPredTarget     execute-stage resolve inputs
//   PCSrc, Mispredict, RedirectPC   resolve outputs
//   BranchCount, MissCount          performance counters
module branch_predictor
  import pc_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned IDX_BITS = 4,
  parameter int unsigned TAG_BITS = XLEN - IDX_BITS - 2,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [XLEN-1:0]  FetchPC,
  output logic             PredTaken,
  output logic [XLEN-1:0]  PredTarget,
  input  logic             ResValid,
  input  logic [XLEN-1:0]  ResPC,
  input  logic [6:0]       OP,
  input  logic [2:0]       Funct3,
  input  logic [3:0]       ONZC,
  input  logic [XLEN-1:0]  ResTarget,
  input  logic             ResPredTaken,
  input  logic [XLEN-1:0]  ResPredTarget,
  output logic [1:0]       PCSrc,
  output logic             Mispredict,
  output logic [XLEN-1:0]  RedirectPC,
  output logic [CNT_W-1:0] BranchCount,
  output logic [CNT_W-1:0] MissCount
);

  localparam int unsigned   ENTRIES = 1 << IDX_BITS;
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  logic                r_valid  [ENTRIES];
  logic [TAG_BITS-1:0] r_tag    [ENTRIES];
  logic [XLEN-1:0]     r_target [ENTRIES];
  ctr_e                r_ctr    [ENTRIES];
  logic [CNT_W-1:0]    r_branch;
  logic [CNT_W-1:0]    r_miss;

  logic [IDX_BITS-1:0] w_fidx, w_ridx;
  logic [TAG_BITS-1:0] w_ftag, w_rtag;
  logic                w_fhit, w_rhit;
  logic                w_dec_taken, w_taken, w_ctrl;
  logic                w_unused;

  assign w_unused = ^{FetchPC[1:0], ResPC[1:0]};

  assign w_fidx = FetchPC[IDX_BITS+1:2];
  assign w_ftag = FetchPC[XLEN-1:IDX_BITS+2];
  assign w_ridx = ResPC[IDX_BITS+1:2];
  assign w_rtag = ResPC[XLEN-1:IDX_BITS+2];

  branch_resolve u_resolve (
    .OP     (OP),
    .Funct3 (Funct3),
    .ONZC   (ONZC),
    .Taken  (w_dec_taken),
    .PCSrc  (PCSrc)
  );

  assign w_ctrl  = ResValid && OP[OP_CTRL_BIT];
  assign w_taken = ResValid && w_dec_taken;

  // Lookup reads the registered table only, so a same-cycle update to the
  // same index is not visible until the next cycle.
  assign w_fhit     = r_valid[w_fidx] && (r_tag[w_fidx] == w_ftag);
  assign PredTaken  = w_fhit && (r_ctr[w_fidx] == WT || r_ctr[w_fidx] == ST);
  assign PredTarget = PredTaken ? r_target[w_fidx] : FetchPC + PC_STEP;

  assign w_rhit     = r_valid[w_ridx] && (r_tag[w_ridx] == w_rtag);
  assign Mispredict = w_ctrl && ((w_taken != ResPredTaken) ||
                                 (w_taken && (ResTarget != ResPredTarget)));
  assign RedirectPC = w_taken ? ResTarget : ResPC + PC_STEP;

  assign BranchCount = r_branch;
  assign MissCount   = r_miss;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_ctr[i]    <= WNT;
      end
      r_branch <= '0;
      r_miss   <= '0;
    end else if (w_ctrl) begin
      if (w_rhit) begin
        r_ctr[w_ridx] <= ctr_next(r_ctr[w_ridx], w_taken);
        if (w_taken) r_target[w_ridx] <= ResTarget;
      end else if (w_taken) begin
        r_valid[w_ridx]  <= 1'b1;
        r_tag[w_ridx]    <= w_rtag;
        r_target[w_ridx] <= ResTarget;
        r_ctr[w_ridx]    <= WT;
      end
      if (r_branch != '1) r_branch <= r_branch + CNT_W'(1);
      if (Mispredict && (r_miss != '1)) r_miss <= r_miss + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

  localparam logic [6:0] BR   = 7'b1100011;
  localparam logic [6:0] JALR = 7'b1100111;
  localparam logic [6:0] JAL  = 7'b1101111;
  localparam logic [6:0] ALU  = 7'b0110011;

  logic        clk;
  logic        reset;
  logic [31:0] FetchPC;
  logic        PredTaken;
  logic [31:0] PredTarget;
  logic        ResValid;
  logic [31:0] ResPC;
  logic [6:0]  OP;
  logic [2:0]  Funct3;
  logic [3:0]  ONZC;
  logic [31:0] ResTarget;
  logic        ResPredTaken;
  logic [31:0] ResPredTarget;
  logic [1:0]  PCSrc;
  logic        Mispredict;
  logic [31:0] RedirectPC;
  logic [4:0]  BranchCount;
  logic [4:0]  MissCount;

  branch_predictor #(.XLEN(32), .IDX_BITS(4), .CNT_W(5)) dut (
    .clk           (clk),
    .reset         (reset),
    .FetchPC       (FetchPC),
    .PredTaken     (PredTaken),
    .PredTarget    (PredTarget),
    .ResValid      (ResValid),
    .ResPC         (ResPC),
    .OP            (OP),
    .Funct3        (Funct3),
    .ONZC          (ONZC),
    .ResTarget     (ResTarget),
    .ResPredTaken  (ResPredTaken),
    .ResPredTarget (ResPredTarget),
    .PCSrc         (PCSrc),
    .Mispredict    (Mispredict),
    .RedirectPC    (RedirectPC),
    .BranchCount   (BranchCount),
    .MissCount     (MissCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] fetch;
    logic        rv;
    logic [31:0] rpc;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [3:0]  onzc;
    logic [31:0] rtgt;
    logic        rpt;
    logic [31:0] rptgt;
    logic        e_pt;
    logic [31:0] e_ptgt;
    logic [1:0]  e_pcsrc;
    logic        e_misp;
    logic [31:0] e_redir;
    int          e_bc;
    int          e_mc;
  } vec_t;

  vec_t vq[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic res(input logic [31:0] fetch, input logic [31:0] rpc,
                     input logic [6:0] op, input logic [2:0] f3,
                     input logic [3:0] onzc, input logic [31:0] rtgt,
                     input logic rpt, input logic [31:0] rptgt,
                     input logic e_pt, input logic [31:0] e_ptgt,
                     input logic [1:0] e_pcsrc, input logic e_misp,
                     input logic [31:0] e_redir, input int e_bc, input int e_mc);
    vec_t v;
    v.fetch = fetch; v.rv = 1'b1; v.rpc = rpc; v.op = op; v.f3 = f3;
    v.onzc = onzc; v.rtgt = rtgt; v.rpt = rpt; v.rptgt = rptgt;
    v.e_pt = e_pt; v.e_ptgt = e_ptgt; v.e_pcsrc = e_pcsrc;
    v.e_misp = e_misp; v.e_redir = e_redir; v.e_bc = e_bc; v.e_mc = e_mc;
    vq.push_back(v);
  endtask

  task automatic idle(input logic [31:0] fetch, input logic e_pt,
                      input logic [31:0] e_ptgt, input int e_bc, input int e_mc);
    vec_t v;
    v.fetch = fetch; v.rv = 1'b0; v.rpc = 32'h0; v.op = ALU; v.f3 = 3'b000;
    v.onzc = 4'b0000; v.rtgt = 32'h0; v.rpt = 1'b0; v.rptgt = 32'h0;
    v.e_pt = e_pt; v.e_ptgt = e_ptgt; v.e_pcsrc = 2'b00;
    v.e_misp = 1'b0; v.e_redir = 32'h4; v.e_bc = e_bc; v.e_mc = e_mc;
    vq.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    FetchPC       = v.fetch;
    ResValid      = v.rv;
    ResPC         = v.rpc;
    OP            = v.op;
    Funct3        = v.f3;
    ONZC          = v.onzc;
    ResTarget     = v.rtgt;
    ResPredTaken  = v.rpt;
    ResPredTarget = v.rptgt;
  endtask

  task automatic chk(input string nm, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s [%0d]: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  initial begin
    // pc  rpc  op  f3 onzc  rtgt  rpt rptgt | pt ptgt pcsrc misp redir bc mc
    res (32'h100, 32'h100, BR, 3'd0, 4'b0010, 32'h80, 1'b0, 32'h0,
         1'b0, 32'h104, 2'b01, 1'b1, 32'h80, 0, 0);                 // 0 beq alloc
    idle(32'h100, 1'b1, 32'h80, 1, 1);                               // 1
    res (32'h100, 32'h100, BR, 3'd0, 4'b0000, 32'h80, 1'b1, 32'h80,
         1'b1, 32'h80, 2'b00, 1'b1, 32'h104, 1, 1);                  // 2 10->01
    res (32'h100, 32'h100, BR, 3'd0, 4'b0000, 32'h80, 1'b0, 32'h0,
         1'b0, 32'h104, 2'b00, 1'b0, 32'h104, 2, 2);                 // 3 01->00
    idle(32'h100, 1'b0, 32'h104, 3, 2);                              // 4
    res (32'h100, 32'h100, BR, 3'd6, 4'b1000, 32'h300, 1'b0, 32'h0,
         1'b0, 32'h104, 2'b01, 1'b1, 32'h300, 3, 2);                 // 5 00->01
    res (32'h100, 32'h100, BR, 3'd6, 4'b1000, 32'h300, 1'b0, 32'h0,
         1'b0, 32'h104, 2'b01, 1'b1, 32'h300, 4, 3);                 // 6 01->10
    res (32'h100, 32'h100, BR, 3'd6, 4'b1000, 32'h300, 1'b1, 32'h300,
         1'b1, 32'h300, 2'b01, 1'b0, 32'h300, 5, 4);                 // 7 10->11
    res (32'h100, 32'h100, BR, 3'd6, 4'b1000, 32'h300, 1'b1, 32'h300,
         1'b1, 32'h300, 2'b01, 1'b0, 32'h300, 6, 4);                 // 8 stays 11
    res (32'h100, 32'h100, BR, 3'd6, 4'b0000, 32'h300, 1'b1, 32'h300,
         1'b1, 32'h300, 2'b00, 1'b1, 32'h104, 7, 4);                 // 9 11->10
    idle(32'h100, 1'b1, 32'h300, 8, 5);                              // 10
    idle(32'h140, 1'b0, 32'h144, 8, 5);                              // 11 alias miss
    res (32'h140, 32'h140, JAL, 3'd0, 4'b0000, 32'h400, 1'b0, 32'h0,
         1'b0, 32'h144, 2'b01, 1'b1, 32'h400, 8, 5);                 // 12 overwrite
    idle(32'h100, 1'b0, 32'h104, 9, 6);                              // 13
    idle(32'h140, 1'b1, 32'h400, 9, 6);                              // 14
    res (32'h200, 32'h180, JALR, 3'd0, 4'b0000, 32'h204, 1'b1, 32'h200,
         1'b0, 32'h204, 2'b10, 1'b1, 32'h204, 9, 6);                 // 15 jalr
    res (32'h180, 32'h180, ALU, 3'd0, 4'b0010, 32'h80, 1'b1, 32'h999,
         1'b1, 32'h204, 2'b00, 1'b0, 32'h184, 10, 7);                // 16 non-control
    idle(32'h180, 1'b1, 32'h204, 10, 7);                             // 17
    res (32'h200, 32'h10, BR, 3'd1, 4'b0000, 32'h50, 1'b0, 32'h0,
         1'b0, 32'h204, 2'b01, 1'b1, 32'h50, 10, 7);                 // 18 bne taken
    res (32'h200, 32'h10, BR, 3'd1, 4'b0010, 32'h50, 1'b1, 32'h50,
         1'b0, 32'h204, 2'b00, 1'b1, 32'h14, 11, 8);                 // 19 bne not
    res (32'h200, 32'h10, BR, 3'd4, 4'b0100, 32'h60, 1'b0, 32'h0,
         1'b0, 32'h204, 2'b01, 1'b1, 32'h60, 12, 9);                 // 20 blt taken
    res (32'h200, 32'h10, BR, 3'd5, 4'b0100, 32'h60, 1'b0, 32'h0,
         1'b0, 32'h204, 2'b00, 1'b0, 32'h14, 13, 10);                // 21 bge not
    res (32'h200, 32'h10, BR, 3'd7, 4'b0000, 32'h60, 1'b1, 32'h60,
         1'b0, 32'h204, 2'b01, 1'b0, 32'h60, 14, 10);                // 22 bgeu taken
    res (32'h200, 32'h10, BR, 3'd2, 4'b1111, 32'h60, 1'b0, 32'h0,
         1'b0, 32'h204, 2'b00, 1'b0, 32'h14, 15, 10);                // 23 f3=010
    res (32'h200, 32'h10, BR, 3'd5, 4'b0000, 32'h60, 1'b1, 32'h64,
         1'b0, 32'h204, 2'b01, 1'b1, 32'h60, 16, 10);                // 24 wrong target
    idle(32'h10, 1'b1, 32'h60, 17, 11);                              // 25
    idle(32'hFFFF_FFFC, 1'b0, 32'h0, 17, 11);                        // 26 wrap

    reset = 1'b1;
    drive(vq[1]);
    FetchPC = 32'h100;
    ResValid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_pt",   -1, {31'b0, PredTaken}, 32'h0);
    chk("rst_ptgt", -1, PredTarget, 32'h104);
    chk("rst_bc",   -1, {27'b0, BranchCount}, 32'h0);
    chk("rst_mc",   -1, {27'b0, MissCount}, 32'h0);
    reset = 1'b0;

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i]);
      #1;
      chk("pred_taken",  i, {31'b0, PredTaken}, {31'b0, vq[i].e_pt});
      chk("pred_target", i, PredTarget, vq[i].e_ptgt);
      chk("pcsrc",       i, {30'b0, PCSrc}, {30'b0, vq[i].e_pcsrc});
      chk("mispredict",  i, {31'b0, Mispredict}, {31'b0, vq[i].e_misp});
      chk("redirect",    i, RedirectPC, vq[i].e_redir);
      chk("branch_cnt",  i, {27'b0, BranchCount}, vq[i].e_bc);
      chk("miss_cnt",    i, {27'b0, MissCount}, vq[i].e_mc);
      @(negedge clk);
    end

    // Perf counter saturation: every jal below mispredicts (ResPredTaken=0).
    for (int k = 0; k < 14; k++) begin
      FetchPC = 32'h200; ResValid = 1'b1; ResPC = 32'h20; OP = JAL;
      Funct3 = 3'd0; ONZC = 4'b0000; ResTarget = 32'h800;
      ResPredTaken = 1'b0; ResPredTarget = 32'h0;
      @(negedge clk);
    end
    ResValid = 1'b0; OP = ALU;
    #1;
    chk("sat_bc_a", 100, {27'b0, BranchCount}, 32'd31);
    chk("sat_mc_a", 100, {27'b0, MissCount}, 32'd25);
    for (int k = 0; k < 10; k++) begin
      ResValid = 1'b1; OP = JAL;
      @(negedge clk);
    end
    ResValid = 1'b0; OP = ALU;
    #1;
    chk("sat_bc_b", 101, {27'b0, BranchCount}, 32'd31);
    chk("sat_mc_b", 101, {27'b0, MissCount}, 32'd31);

    // Reset and a taken resolve in the same cycle: reset must win.
    reset = 1'b1;
    FetchPC = 32'h300; ResValid = 1'b1; ResPC = 32'h300; OP = BR;
    Funct3 = 3'd0; ONZC = 4'b0010; ResTarget = 32'h900;
    ResPredTaken = 1'b0; ResPredTarget = 32'h0;
    @(negedge clk);
    reset = 1'b0;
    ResValid = 1'b0; OP = ALU;
    #1;
    chk("rstcol_pt",   102, {31'b0, PredTaken}, 32'h0);
    chk("rstcol_ptgt", 102, PredTarget, 32'h304);
    chk("rstcol_bc",   102, {27'b0, BranchCount}, 32'h0);
    chk("rstcol_mc",   102, {27'b0, MissCount}, 32'h0);
    @(negedge clk);
    #1;
    chk("rstcol_pt2",  103, {31'b0, PredTaken}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
